// File: rtl/gun_cursor_ctrl.sv
// Cursor position controller for the williams2 light-gun inputs: digital joystick with
// per-axis acceleration and a relative mouse stream, both paced by the 4 ms game strobe.
module gun_cursor_ctrl #(
    parameter int POS_MAX     = 63,
    parameter int CENTER      = 32,
    parameter int SLOW_DIV    = 2,
    parameter int ACCEL_HOLD  = 8,
    parameter int FAST_STEP   = 2,
    parameter int MOUSE_SHIFT = 2
) (
    input  logic       clk_12,
    input  logic       reset,
    input  logic       tick_4ms,
    input  logic       joy_left,
    input  logic       joy_right,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       recenter,
    input  logic       mouse_valid,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    output logic       mouse_ready,
    output logic [5:0] gun_h,
    output logic [5:0] gun_v,
    output logic       src_mouse,
    output logic       gun_upd
);

    localparam int                 DIV_W     = $clog2(SLOW_DIV + 1);
    localparam int                 HOLD_W    = $clog2(ACCEL_HOLD + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(ACCEL_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [5:0]         CENTER_P  = 6'(CENTER);
    localparam logic [5:0]         POS_MAX_P = 6'(POS_MAX);
    localparam logic signed [12:0] POS_MAX_S = 13'(POS_MAX);
    localparam logic signed [12:0] ACC_MAX   = 13'sd2047;
    localparam logic signed [12:0] ACC_MIN   = -13'sd2047;
    localparam logic [11:0]        RES_MASK  = 12'((1 << MOUSE_SHIFT) - 1);
    localparam logic signed [3:0]  STEP_ONE  = 4'sd1;
    localparam logic signed [3:0]  STEP_FAST = 4'(FAST_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } axis_st_e;

    typedef struct packed {
        axis_st_e            st;
        logic                dir_neg;
        logic [DIV_W-1:0]    div;
        logic [HOLD_W-1:0]   hold;
    } axis_t;

    localparam axis_t AXIS_IDLE = '{st: ST_IDLE, dir_neg: 1'b0, div: '0, hold: '0};

    // One tick of the acceleration machine; hold reaching ACCEL_HOLD takes effect on the following tick.
    function automatic axis_t axis_next(input axis_t cur, input logic mv, input logic neg,
                                        output logic signed [3:0] step);
        axis_t             nxt;
        logic signed [3:0] unit;
        nxt  = cur;
        step = 4'sd0;
        unit = neg ? -STEP_ONE : STEP_ONE;
        case (cur.st)
            ST_IDLE: begin
                if (mv) begin
                    nxt  = '{st: ST_SLOW, dir_neg: neg, div: '0, hold: HOLD_ONE};
                    step = unit;
                end else begin
                    nxt = AXIS_IDLE;
                end
            end
            ST_SLOW, ST_FAST: begin
                if (!mv) begin
                    nxt = AXIS_IDLE;
                end else if (neg != cur.dir_neg) begin
                    nxt  = '{st: ST_SLOW, dir_neg: neg, div: '0, hold: HOLD_ONE};
                    step = unit;
                end else if (cur.st == ST_FAST) begin
                    step = neg ? -STEP_FAST : STEP_FAST;
                end else begin
                    if (cur.div == DIV_LAST) begin
                        nxt.div = '0;
                        step    = unit;
                    end else begin
                        nxt.div = cur.div + DIV_ONE;
                    end
                    if (cur.hold == HOLD_MAX) begin
                        nxt.st = ST_FAST;
                    end else begin
                        nxt.hold = cur.hold + HOLD_ONE;
                    end
                end
            end
            default: nxt = AXIS_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [5:0] sat_pos(input logic [5:0] pos, input logic signed [12:0] delta);
        logic signed [12:0] sum;
        sum = $signed({7'd0, pos}) + delta;
        if (sum < 13'sd0) begin
            return 6'd0;
        end else if (sum > POS_MAX_S) begin
            return POS_MAX_P;
        end else begin
            return sum[5:0];
        end
    endfunction

    function automatic logic signed [11:0] acc_add(input logic signed [11:0] acc, input logic [8:0] d);
        logic signed [12:0] sum;
        sum = $signed({acc[11], acc}) + $signed({{4{d[8]}}, d});
        if (sum > ACC_MAX) begin
            return 12'sd2047;
        end else if (sum < ACC_MIN) begin
            return -12'sd2047;
        end else begin
            return sum[11:0];
        end
    endfunction

    logic                tick_d_r, run_r, src_r, upd_r;
    logic [5:0]          h_r, v_r, h_s, v_s;
    axis_t               ax_h_r, ax_v_r, ax_h_s, ax_v_s, ax_h_t, ax_v_t;
    logic signed [11:0]  acc_x_r, acc_y_r, acc_x_s, acc_y_s;
    logic signed [11:0]  q_x_s, q_y_s;
    logic signed [3:0]   step_h_s, step_v_s;
    logic                src_s, tick_rise_s, ready_s, accept_s, any_joy_s;

    assign tick_rise_s = tick_4ms & ~tick_d_r;
    assign ready_s     = run_r & ~tick_rise_s;
    assign accept_s    = mouse_valid & ready_s;
    assign any_joy_s   = joy_left | joy_right | joy_up | joy_down;

    // Candidate joystick FSM step per axis; opposing directions cancel to "no move".
    always_comb begin
        ax_h_t = axis_next(ax_h_r, joy_left ^ joy_right, joy_left & ~joy_right, step_h_s);
        ax_v_t = axis_next(ax_v_r, joy_up ^ joy_down, joy_up & ~joy_down, step_v_s);
    end

    // Next-state arbitration: recenter, then tick-paced moves, then mouse accumulation.
    always_comb begin
        h_s     = h_r;
        v_s     = v_r;
        ax_h_s  = ax_h_r;
        ax_v_s  = ax_v_r;
        acc_x_s = acc_x_r;
        acc_y_s = acc_y_r;
        src_s   = src_r;
        q_x_s   = acc_x_r >>> MOUSE_SHIFT;
        q_y_s   = acc_y_r >>> MOUSE_SHIFT;
        if (recenter) begin
            // A packet accepted in this cycle is discarded along with the accumulators.
            h_s     = CENTER_P;
            v_s     = CENTER_P;
            ax_h_s  = AXIS_IDLE;
            ax_v_s  = AXIS_IDLE;
            acc_x_s = 12'sd0;
            acc_y_s = 12'sd0;
        end else if (tick_rise_s) begin
            ax_h_s = ax_h_t;
            ax_v_s = ax_v_t;
            if (any_joy_s) begin
                h_s     = sat_pos(h_r, {{9{step_h_s[3]}}, step_h_s});
                v_s     = sat_pos(v_r, {{9{step_v_s[3]}}, step_v_s});
                src_s   = 1'b0;
                acc_x_s = 12'sd0;
                acc_y_s = 12'sd0;
            end else if (src_r) begin
                h_s     = sat_pos(h_r, {q_x_s[11], q_x_s});
                v_s     = sat_pos(v_r, {q_y_s[11], q_y_s});
                acc_x_s = $signed(acc_x_r & RES_MASK);
                acc_y_s = $signed(acc_y_r & RES_MASK);
            end else begin
                src_s = src_r;
            end
        end else if (accept_s) begin
            acc_x_s = acc_add(acc_x_r, mouse_dx);
            acc_y_s = acc_add(acc_y_r, mouse_dy);
            if ((mouse_dx != 9'd0) || (mouse_dy != 9'd0)) begin
                src_s = 1'b1;
            end else begin
                src_s = src_r;
            end
        end else begin
            src_s = src_r;
        end
    end

    // State registers; gun_upd flags a real change of either position.
    always_ff @(posedge clk_12 or negedge reset) begin
        if (!reset) begin
            tick_d_r <= 1'b0;
            run_r    <= 1'b0;
            h_r      <= CENTER_P;
            v_r      <= CENTER_P;
            ax_h_r   <= AXIS_IDLE;
            ax_v_r   <= AXIS_IDLE;
            acc_x_r  <= 12'sd0;
            acc_y_r  <= 12'sd0;
            src_r    <= 1'b0;
            upd_r    <= 1'b0;
        end else begin
            tick_d_r <= tick_4ms;
            run_r    <= 1'b1;
            h_r      <= h_s;
            v_r      <= v_s;
            ax_h_r   <= ax_h_s;
            ax_v_r   <= ax_v_s;
            acc_x_r  <= acc_x_s;
            acc_y_r  <= acc_y_s;
            src_r    <= src_s;
            upd_r    <= (h_s != h_r) || (v_s != v_r);
        end
    end

    assign mouse_ready = ready_s;
    assign gun_h       = h_r;
    assign gun_v       = v_r;
    assign src_mouse   = src_r;
    assign gun_upd     = upd_r;

endmodule

// File: tb/tb_gun_cursor_ctrl.sv
// Directed bench for gun_cursor_ctrl: a tick-by-tick vector table for the joystick
// ramp, plus hand-written sequences for mouse, arbitration, saturation, recenter and reset.
module tb_gun_cursor_ctrl;

    logic       clk_12 = 1'b0;
    logic       reset = 1'b0;
    logic       tick_4ms = 1'b0;
    logic       joy_left = 1'b0, joy_right = 1'b0, joy_up = 1'b0, joy_down = 1'b0;
    logic       recenter = 1'b0;
    logic       mouse_valid = 1'b0;
    logic [8:0] mouse_dx = 9'd0, mouse_dy = 9'd0;
    logic       mouse_ready, src_mouse, gun_upd;
    logic [5:0] gun_h, gun_v;

    int n_vec = 0;
    int n_bad = 0;

    gun_cursor_ctrl dut (
        .clk_12     (clk_12),
        .reset      (reset),
        .tick_4ms   (tick_4ms),
        .joy_left   (joy_left),
        .joy_right  (joy_right),
        .joy_up     (joy_up),
        .joy_down   (joy_down),
        .recenter   (recenter),
        .mouse_valid(mouse_valid),
        .mouse_dx   (mouse_dx),
        .mouse_dy   (mouse_dy),
        .mouse_ready(mouse_ready),
        .gun_h      (gun_h),
        .gun_v      (gun_v),
        .src_mouse  (src_mouse),
        .gun_upd    (gun_upd)
    );

    always #5 clk_12 = ~clk_12;

    typedef struct {
        logic [3:0] joy;   // {left, right, up, down}
        logic       rc;
        logic [5:0] h;
        logic [5:0] v;
        logic       upd;
        logic       src;
    } vec_t;

    vec_t vecs [25];
    int   exp_rh [12] = '{33, 33, 34, 34, 35, 35, 36, 36, 37, 39, 41, 43};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [5:0] h, input logic [5:0] v,
                             input logic upd, input logic src);
        check({name, ".gun_h"}, 32'(gun_h), 32'(h));
        check({name, ".gun_v"}, 32'(gun_v), 32'(v));
        check({name, ".gun_upd"}, 32'(gun_upd), 32'(upd));
        check({name, ".src_mouse"}, 32'(src_mouse), 32'(src));
    endtask

    // One strobe rising edge; returns at the negedge right after the update edge.
    task automatic pulse_tick(input logic [3:0] joy);
        @(negedge clk_12);
        {joy_left, joy_right, joy_up, joy_down} = joy;
        tick_4ms = 1'b1;
        @(negedge clk_12);
        tick_4ms = 1'b0;
    endtask

    task automatic pulse_rc(input logic [3:0] joy);
        @(negedge clk_12);
        {joy_left, joy_right, joy_up, joy_down} = joy;
        recenter = 1'b1;
        @(negedge clk_12);
        recenter = 1'b0;
    endtask

    task automatic send_mouse(input logic [8:0] dx, input logic [8:0] dy);
        @(negedge clk_12);
        mouse_valid = 1'b1;
        mouse_dx    = dx;
        mouse_dy    = dy;
        for (int i = 0; i < 20 && !mouse_ready; i++) @(negedge clk_12);
        check("mouse_ready_wait", 32'(mouse_ready), 32'd1);
        @(negedge clk_12);
        mouse_valid = 1'b0;
        mouse_dx    = 9'd0;
        mouse_dy    = 9'd0;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Vector table: joystick ramp right, release, recenter, both-pressed cancel, idle recenter.
        for (int i = 0; i < 12; i++)
            vecs[i] = '{joy: 4'b0100, rc: 1'b0, h: 6'(exp_rh[i]), v: 6'd32,
                        upd: 1'((i % 2 == 0) || (i >= 8)), src: 1'b0};
        vecs[12] = '{joy: 4'b0000, rc: 1'b0, h: 6'd43, v: 6'd32, upd: 1'b0, src: 1'b0};
        vecs[13] = '{joy: 4'b0000, rc: 1'b1, h: 6'd32, v: 6'd32, upd: 1'b1, src: 1'b0};
        for (int i = 14; i < 24; i++)
            vecs[i] = '{joy: 4'b1100, rc: 1'b0, h: 6'd32, v: 6'd32, upd: 1'b0, src: 1'b0};
        vecs[24] = '{joy: 4'b0000, rc: 1'b1, h: 6'd32, v: 6'd32, upd: 1'b0, src: 1'b0};

        repeat (3) @(negedge clk_12);
        check_out("reset", 6'd32, 6'd32, 1'b0, 1'b0);
        check("reset.mouse_ready", 32'(mouse_ready), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            if (vecs[i].rc) pulse_rc(vecs[i].joy);
            else            pulse_tick(vecs[i].joy);
            check_out($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].upd, vecs[i].src);
        end

        // Mouse: +7 then -2 gives acc 5 -> one step, residual 1; +3 brings it to 4 -> one step.
        send_mouse(9'd7, 9'd0);
        send_mouse(9'h1FE, 9'd0);
        pulse_tick(4'b0000);
        check_out("mouse_first", 6'd33, 6'd32, 1'b1, 1'b1);
        send_mouse(9'd3, 9'd0);
        pulse_tick(4'b0000);
        check_out("mouse_residual", 6'd34, 6'd32, 1'b1, 1'b1);

        // Packet offered in the tick_rise cycle is refused and accepted a cycle later.
        @(negedge clk_12);
        tick_4ms    = 1'b1;
        mouse_valid = 1'b1;
        mouse_dx    = 9'd4;
        #1 check("ready_in_tick", 32'(mouse_ready), 32'd0);
        @(negedge clk_12);
        check_out("held_tick", 6'd34, 6'd32, 1'b0, 1'b1);
        check("ready_after_tick", 32'(mouse_ready), 32'd1);
        tick_4ms = 1'b0;
        @(negedge clk_12);
        mouse_valid = 1'b0;
        mouse_dx    = 9'd0;
        pulse_tick(4'b0000);
        check_out("held_applied", 6'd35, 6'd32, 1'b1, 1'b1);

        // Joystick pre-empts the mouse and clears its accumulators.
        send_mouse(9'd9, 9'd0);
        pulse_tick(4'b1000);
        check_out("joy_preempt", 6'd34, 6'd32, 1'b1, 1'b0);
        pulse_tick(4'b0000);
        check_out("joy_release", 6'd34, 6'd32, 1'b0, 1'b0);
        send_mouse(9'd1, 9'd0);
        check("src_after_dx1", 32'(src_mouse), 32'd1);
        pulse_tick(4'b0000);
        check_out("acc_cleared", 6'd34, 6'd32, 1'b0, 1'b1);

        // Vertical: nudge to 33 with the mouse, then ramp down into FAST up to the limit.
        send_mouse(9'd0, 9'd4);
        pulse_tick(4'b0000);
        check_out("mouse_dy", 6'd34, 6'd33, 1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            pulse_tick(4'b0001);
            if (i == 9) check_out("down_fast_entry", 6'd34, 6'd38, 1'b1, 1'b0);
        end
        check("down_at_60", 32'(gun_v), 32'd60);
        pulse_tick(4'b0001);
        check_out("down_62", 6'd34, 6'd62, 1'b1, 1'b0);
        pulse_tick(4'b0001);
        check_out("down_63", 6'd34, 6'd63, 1'b1, 1'b0);
        pulse_tick(4'b0001);
        check_out("down_sat", 6'd34, 6'd63, 1'b0, 1'b0);
        pulse_tick(4'b0000);
        check_out("down_release", 6'd34, 6'd63, 1'b0, 1'b0);
        pulse_tick(4'b0010);
        check_out("up_after_sat", 6'd34, 6'd62, 1'b1, 1'b0);

        // Move to 50 with the mouse, then recenter together with tick_rise and joy_right.
        send_mouse(9'd64, 9'd0);
        pulse_tick(4'b0000);
        check_out("mouse_to_50", 6'd50, 6'd62, 1'b1, 1'b1);
        @(negedge clk_12);
        {joy_left, joy_right, joy_up, joy_down} = 4'b0100;
        tick_4ms = 1'b1;
        recenter = 1'b1;
        @(negedge clk_12);
        recenter = 1'b0;
        tick_4ms = 1'b0;
        check_out("rc_over_tick", 6'd32, 6'd32, 1'b1, 1'b1);
        @(negedge clk_12);
        check("rc_single_pulse", 32'(gun_upd), 32'd0);

        // Ramp right into FAST, then assert reset mid-move.
        pulse_tick(4'b0100);
        check_out("ramp_start", 6'd33, 6'd32, 1'b1, 1'b0);
        repeat (11) pulse_tick(4'b0100);
        check("ramp_end", 32'(gun_h), 32'd43);
        @(negedge clk_12);
        #2 reset = 1'b0;
        #1 check_out("midreset", 6'd32, 6'd32, 1'b0, 1'b0);
        check("midreset.mouse_ready", 32'(mouse_ready), 32'd0);
        @(negedge clk_12);
        reset = 1'b1;
        #1 check("ready_before_run", 32'(mouse_ready), 32'd0);
        @(negedge clk_12);
        check("ready_after_run", 32'(mouse_ready), 32'd1);
        pulse_tick(4'b0100);
        check_out("after_reset_idle", 6'd33, 6'd32, 1'b1, 1'b0);

        {joy_left, joy_right, joy_up, joy_down} = 4'b0000;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
